// File: rtl/bus_master_ctrl.sv
// rtl/bus_master_ctrl.sv - CPU load/store to cyc/stb/ack bus cycle controller
// with big-endian lane select, bus error and timeout handling.
module bus_master_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] cpu_o,
    input  logic [31:0] cpu_i,
    input  logic        ack_i,
    input  logic        err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter compares against TIMEOUT-1 so the strobe stays up exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       lane_sel;
    logic             lane_ok;

    always_comb begin
        lane_sel = 4'b0000;
        lane_ok  = 1'b0;
        case (cpu_size)
            2'b00: begin
                lane_ok  = 1'b1;
                lane_sel = 4'b1000 >> cpu_addr[1:0];
            end
            2'b01: begin
                if (!cpu_addr[0]) begin
                    lane_ok  = 1'b1;
                    lane_sel = cpu_addr[1] ? 4'b0011 : 4'b1100;
                end
            end
            2'b10: begin
                if (cpu_addr[1:0] == 2'b00) begin
                    lane_ok  = 1'b1;
                    lane_sel = 4'b1111;
                end
            end
            default: begin
                lane_ok  = 1'b0;
                lane_sel = 4'b0000;
            end
        endcase
    end

    assign stb_o = cyc_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cyc_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= 32'h0;
            sel_o     <= 4'b0000;
            cpu_o     <= 32'h0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (lane_ok) begin
                            cyc_o <= 1'b1;
                            we_o  <= cpu_we;
                            adr_o <= {cpu_addr[31:2], 2'b00};
                            sel_o <= lane_sel;
                            cpu_o <= cpu_wdata;
                            cnt   <= '0;
                            state <= S_BUS;
                        end else begin
                            // Misaligned: fail straight back to the CPU, bus untouched.
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_BUS: begin
                    if (ack_i) begin
                        if (!we_o) begin
                            cpu_rdata <= cpu_i;
                        end
                        cyc_o   <= 1'b0;
                        cpu_ack <= 1'b1;
                        cpu_err <= 1'b0;
                        state   <= S_DONE;
                    end else if (err_i || (cnt == CNT_LAST)) begin
                        cyc_o   <= 1'b0;
                        cpu_ack <= 1'b1;
                        cpu_err <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    cpu_ack <= 1'b0;
                    cpu_err <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
